// File: rtl/round_arbiter_pkg.sv
// round_pkg: rounding-mode codes and the mode-dependent addend generator
// shared by the rounding unit. The rnd_const() helper builds the F-bit
// addend that, added to the sample and truncated, implements each mode.
// Optional build macro (consumed by round_mode_unit): ROUNDING_SAT_EN.
package round_pkg;

  localparam logic [2:0] RND_TRUNC = 3'd0;
  localparam logic [2:0] RND_HUP   = 3'd1;
  localparam logic [2:0] RND_HDN   = 3'd2;
  localparam logic [2:0] RND_TZERO = 3'd3;
  localparam logic [2:0] RND_AZERO = 3'd4;
  localparam logic [2:0] RND_CONV  = 3'd5;

  // Addend container width; callers cast down to their sample width.
  localparam int RND_CW = 32;

  // Addend is {msb, (f-1) copies of fill} in the low f bits.
  // Codes 6/7 fall into default and behave as truncate.
  function automatic logic [RND_CW-1:0] rnd_const(input logic [2:0] mode,
                                                  input logic       sign,
                                                  input logic       kbit,
                                                  input int         f);
    logic              msb;
    logic              fill;
    logic [RND_CW-1:0] ones;
    msb  = 1'b0;
    fill = 1'b0;
    case (mode)
      RND_HUP:   msb = 1'b1;
      RND_HDN:   fill = 1'b1;
      RND_TZERO: begin msb = sign;  fill = !sign; end
      RND_AZERO: begin msb = !sign; fill = sign;  end
      RND_CONV:  begin msb = kbit;  fill = !kbit; end
      default:   ;
    endcase
    ones = (RND_CW'(1) << (f - 1)) - RND_CW'(1);
    rnd_const = ({{(RND_CW-1){1'b0}}, msb} << (f - 1)) | (fill ? ones : '0);
  endfunction

endpackage

// File: rtl/round_arbiter_mode.sv
// round_mode_unit: combinational IWID -> OWID rounding.
//   i_data  IWID-bit two's-complement sample
//   i_mode  3-bit rounding-mode code
//   o_data  OWID-bit rounded result
// Macro ROUNDING_SAT_EN: when defined, positive overflow clamps to max
// positive; otherwise the sum wraps (carry out of the MSB is dropped).
module round_mode_unit
  import round_pkg::*;
#(
  parameter int IWID = 8,
  parameter int OWID = 5
) (
  input  logic [IWID-1:0] i_data,
  input  logic [2:0]      i_mode,
  output logic [OWID-1:0] o_data
);

  localparam int F = IWID - OWID;

  logic [IWID-1:0] w_add;
  logic [IWID-1:0] w_sum;
  logic [OWID-1:0] w_trunc;
  logic            w_frac_unused;

  // Convergent mode uses bit F (the result LSB) as its tie-break bit.
  assign w_add   = IWID'(rnd_const(i_mode, i_data[IWID-1], i_data[F], F));
  assign w_sum   = i_data + w_add;
  assign w_trunc = w_sum[IWID-1:F];
  assign w_frac_unused = ^w_sum[F-1:0];

`ifdef ROUNDING_SAT_EN
  // Only a non-negative input can carry into the sign bit.
  assign o_data = (w_sum[IWID-1] && !i_data[IWID-1]) ?
                  {1'b0, {(OWID-1){1'b1}}} : w_trunc;
`else
  assign o_data = w_trunc;
`endif

endmodule

// File: rtl/round_arbiter.sv
// round_arbiter: NREQ requesters share one 2-stage rounding pipeline.
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_valid/o_ready    per-requester handshake (o_ready one-hot)
//   i_data, i_mode     packed samples / mode codes, requester k at slot k
//   o_valid/i_ready    result handshake with backpressure
//   o_data/o_id/o_mode rounded result, winner's index, raw mode code
// Optional build macro ROUNDING_SAT_EN (see round_mode_unit).
module round_arbiter
  import round_pkg::*;
#(
  parameter int IWID = 8,
  parameter int OWID = 5,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NREQ-1:0]      i_valid,
  input  logic [NREQ*IWID-1:0] i_data,
  input  logic [NREQ*3-1:0]    i_mode,
  output logic [NREQ-1:0]      o_ready,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OWID-1:0]      o_data,
  output logic [IDW-1:0]       o_id,
  output logic [2:0]           o_mode
);

  logic            r_s1_valid;
  logic [IWID-1:0] r_s1_data;
  logic [2:0]      r_s1_mode;
  logic [IDW-1:0]  r_s1_id;
  logic [IDW-1:0]  r_rr;
  logic            r_o_valid;
  logic [OWID-1:0] r_o_data;
  logic [IDW-1:0]  r_o_id;
  logic [2:0]      r_o_mode;

  logic            w_s1_adv, w_adv, w_gnt_vld, w_xfer;
  logic [IDW-1:0]  w_gnt, w_rr_nxt;
  logic [OWID-1:0] w_rnd;

  assign w_s1_adv = !r_o_valid || i_ready;
  assign w_adv    = !r_s1_valid || w_s1_adv;

  // Round-robin search from r_rr; descending scan so the smallest
  // offset from the pointer is the one left standing.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (i_valid[(int'(r_rr) + j) % NREQ]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = IDW'((int'(r_rr) + j) % NREQ);
      end
    end
  end

  // Gating with i_reset_n keeps o_ready low while reset is asserted.
  assign w_xfer   = w_gnt_vld && w_adv && i_reset_n;
  assign w_rr_nxt = (int'(w_gnt) == NREQ - 1) ? '0 : w_gnt + IDW'(1);

  always_comb begin
    for (int k = 0; k < NREQ; k++)
      o_ready[k] = w_xfer && (w_gnt == IDW'(k));
  end

  round_mode_unit #(.IWID(IWID), .OWID(OWID)) u_rnd (
    .i_data (r_s1_data),
    .i_mode (r_s1_mode),
    .o_data (w_rnd)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rr       <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= '0;
      r_s1_id    <= '0;
      r_o_valid  <= 1'b0;
      r_o_data   <= '0;
      r_o_id     <= '0;
      r_o_mode   <= '0;
    end else begin
      // S1 refill may coincide with S1 -> S2 move (no bubble).
      if (w_xfer) begin
        r_rr       <= w_rr_nxt;
        r_s1_valid <= 1'b1;
        r_s1_data  <= i_data[w_gnt*IWID +: IWID];
        r_s1_mode  <= i_mode[w_gnt*3 +: 3];
        r_s1_id    <= w_gnt;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s1_adv) begin
        r_o_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_o_data <= w_rnd;
          r_o_id   <= r_s1_id;
          r_o_mode <= r_s1_mode;
        end
      end
    end
  end

  assign o_valid = r_o_valid;
  assign o_data  = r_o_data;
  assign o_id    = r_o_id;
  assign o_mode  = r_o_mode;

endmodule

// File: tb/tb_round_arbiter.sv
// Self-checking bench for round_arbiter (IWID=8, OWID=5, NREQ=4).
// Honours ROUNDING_SAT_EN for the saturating build.
module tb_round_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [3:0]  i_valid;
  logic [31:0] i_data;
  logic [11:0] i_mode;
  logic [3:0]  o_ready;
  logic        o_valid;
  logic        i_ready;
  logic [4:0]  o_data;
  logic [1:0]  o_id;
  logic [2:0]  o_mode;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] id;
    logic [2:0] mode;
    logic [4:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic [7:0] d;
    logic [2:0] m;
    logic [4:0] exp;
  } vec_t;
  vec_t vec[14];

  round_arbiter #(.IWID(8), .OWID(5), .NREQ(4), .IDW(2)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_data(i_data),
    .i_mode(i_mode), .o_ready(o_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_id(o_id), .o_mode(o_mode)
  );

  always #5 i_clk = ~i_clk;

  // Reference rounding: floor plus mode-dependent increment on the
  // 3-bit fraction.
  function automatic logic [4:0] model(input logic [7:0] d, input logic [2:0] m);
    int v, fl, fr, inc, r;
    bit pos;
    v   = int'($signed(d));
    fl  = v >>> 3;
    fr  = v & 7;
    pos = (v >= 0);
    case (m)
      3'd1:    inc = (fr >= 4) ? 1 : 0;
      3'd2:    inc = (fr > 4) ? 1 : 0;
      3'd3:    inc = pos ? ((fr > 4) ? 1 : 0) : ((fr >= 4) ? 1 : 0);
      3'd4:    inc = pos ? ((fr >= 4) ? 1 : 0) : ((fr > 4) ? 1 : 0);
      3'd5:    inc = ((fr > 4) || (fr == 4 && fl[0])) ? 1 : 0;
      default: inc = 0;
    endcase
    r = fl + inc;
`ifdef ROUNDING_SAT_EN
    if (pos && r > 15) r = 15;
`endif
    return r[4:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Scoreboard: push on every accepted request, pop on every delivered result.
  always @(negedge i_clk) begin
    if (!i_reset_n) begin
      sb.delete();
    end else begin
      if (o_valid && i_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra actual id=%0d data=%h required no result", o_id, o_data);
        end else begin
          mon_e = sb.pop_front();
          if (o_id !== mon_e.id || o_mode !== mon_e.mode || o_data !== mon_e.data) begin
            errors++;
            $display("FAIL sb_result actual id=%0d mode=%0d data=%h required id=%0d mode=%0d data=%h",
                     o_id, o_mode, o_data, mon_e.id, mon_e.mode, mon_e.data);
          end
        end
      end
      for (int k = 0; k < 4; k++)
        if (i_valid[k] && o_ready[k])
          sb.push_back('{id: 2'(k), mode: i_mode[k*3 +: 3],
                         data: model(i_data[k*8 +: 8], i_mode[k*3 +: 3])});
    end
  end

  // Single request on requester 0; lat = cycles from accept to o_valid.
  task automatic send1(input logic [7:0] d, input logic [2:0] m,
                       output logic [4:0] r, output int lat);
    bit acc, got;
    @(posedge i_clk); #1;
    i_data[7:0] = d;
    i_mode[2:0] = m;
    i_valid     = 4'b0001;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge i_clk);
      acc = o_ready[0];
    end
    if (!acc) chk("accept_timeout", 32'(o_ready), 32'h1);
    @(posedge i_clk); #1;
    i_valid = 4'b0000;
    lat = 0;
    got = 1'b0;
    r   = 'x;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge i_clk);
      lat++;
      if (o_valid) begin
        got = 1'b1;
        r   = o_data;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] r;
    int         lat;
    logic [4:0] d0;
    logic [1:0] id0;

    vec[0]  = '{8'h0C, 3'd0, 5'h01};
    vec[1]  = '{8'h0C, 3'd1, 5'h02};
    vec[2]  = '{8'h0C, 3'd2, 5'h01};
    vec[3]  = '{8'h0C, 3'd3, 5'h01};
    vec[4]  = '{8'h0C, 3'd4, 5'h02};
    vec[5]  = '{8'h0C, 3'd5, 5'h02};
    vec[6]  = '{8'h14, 3'd5, 5'h02};
    vec[7]  = '{8'hF4, 3'd0, 5'h1E};
    vec[8]  = '{8'hF4, 3'd3, 5'h1F};
    vec[9]  = '{8'hF4, 3'd4, 5'h1E};
`ifdef ROUNDING_SAT_EN
    vec[10] = '{8'h7F, 3'd1, 5'h0F};
`else
    vec[10] = '{8'h7F, 3'd1, 5'h10};
`endif
    vec[11] = '{8'h0C, 3'd6, 5'h01};
    vec[12] = '{8'h80, 3'd1, 5'h10};
    vec[13] = '{8'h7F, 3'd7, 5'h0F};

    i_reset_n = 1'b0;
    i_valid   = 4'b1111;
    i_data    = '0;
    i_mode    = '0;
    i_ready   = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_o_valid", 32'(o_valid), 32'h0);
    chk("reset_o_ready", 32'(o_ready), 32'h0);
    chk("reset_outputs", {22'h0, o_mode, o_id, o_data}, 32'h0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    i_valid   = 4'b0000;

    for (int i = 0; i < 14; i++) begin
      send1(vec[i].d, vec[i].m, r, lat);
      chk($sformatf("vec%0d_data", i), 32'(r), 32'(vec[i].exp));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    // All four valid; last transfer was requester 0, so rotation starts at 1.
    @(posedge i_clk); #1;
    i_data  = {8'h34, 8'h2C, 8'h1C, 8'hF4};
    i_mode  = {3'd5, 3'd4, 3'd1, 3'd3};
    i_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      @(negedge i_clk);
      chk("rr_grant", 32'(o_ready), 32'(1) << ((1 + n) % 4));
      if (n >= 2) begin
        chk("rr_o_valid", 32'(o_valid), 32'h1);
        chk("rr_o_id", 32'(o_id), 32'((1 + n - 2) % 4));
      end
    end

    // Backpressure with a full pipeline.
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    @(negedge i_clk);
    d0  = o_data;
    id0 = o_id;
    chk("stall_ready0", 32'(o_ready), 32'h0);
    for (int s = 1; s < 5; s++) begin
      @(negedge i_clk);
      chk("stall_hold", {25'h0, o_valid, o_id, o_data}, {25'h0, 1'b1, id0, d0});
      chk("stall_ready", 32'(o_ready), 32'h0);
    end
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    i_valid = 4'b0000;
    repeat (4) @(negedge i_clk);
    chk("drain_empty", 32'(sb.size()), 32'h0);
    chk("drain_o_valid", 32'(o_valid), 32'h0);

    // Idle cycles must not move the pointer.
    @(posedge i_clk); #1;
    i_valid = 4'b0010;
    @(negedge i_clk);
    chk("idle_pre_grant", 32'(o_ready), 32'h2);
    @(posedge i_clk); #1;
    i_valid = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      @(negedge i_clk);
      chk("idle_no_grant", 32'(o_ready), 32'h0);
    end
    @(posedge i_clk); #1;
    i_valid = 4'b1111;
    @(negedge i_clk);
    chk("idle_rr_hold", 32'(o_ready), 32'h4);

    // Single persistent requester, fresh random sample each cycle.
    @(posedge i_clk); #1;
    i_valid = 4'b0100;
    for (int n = 0; n < 24; n++) begin
      @(negedge i_clk);
      chk("single_grant", 32'(o_ready), 32'h4);
      @(posedge i_clk); #1;
      i_data[16 +: 8] = 8'($urandom);
      i_mode[6 +: 3]  = 3'($urandom_range(0, 7));
    end
    i_valid = 4'b0000;
    repeat (4) @(negedge i_clk);
    chk("single_drain", 32'(sb.size()), 32'h0);

    // Reset mid-stream.
    @(posedge i_clk); #1;
    i_valid = 4'b1111;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset_n = 1'b0;
    @(negedge i_clk);
    chk("midrst_ready", 32'(o_ready), 32'h0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    i_valid   = 4'b1100;
    @(negedge i_clk);
    chk("midrst_o_valid", 32'(o_valid), 32'h0);
    chk("midrst_first_grant", 32'(o_ready), 32'h4);
    @(posedge i_clk); #1;
    i_valid = 4'b0000;
    repeat (4) @(negedge i_clk);
    chk("midrst_drain", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
